// File: rtl/cache_arbiter_8051.sv
// ---------------------------------------------------------------------------
// cache_arbiter_8051
//
// Sequencing controller and two-port arbiter in front of the 8051
// direct-mapped byte cache. The single cache lookup port is shared between
// the code-fetch requester (port 0) and the XDATA requester (port 1).
//
// Reads do a one-cycle lookup. A read miss is refilled from external memory
// and then written into the cache. Writes are write-through/write-allocate:
// the data goes to external memory first and is then written into the cache.
//
// Build option:
//   CACHE_ARB_FIXED_PRIO_EN  defined     -> fixed priority (req0 always wins)
//                            not defined -> round-robin between the ports
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   req*/addr*/wr*/wdata*     requester side (held stable until ack*)
//   ack0, ack1, rdata         one-cycle completion pulse and read data
//   c_rd, c_fill, c_addr,
//   c_wdata, c_hit, c_rdata   cache array lookup/fill port
//   m_req, m_we, m_addr,
//   m_wdata, m_ack, m_rdata   handshaked external memory port
//   busy, gnt, miss_cnt       status: not idle, served port, read-miss count
// All outputs are registered and reset to zero.
// ---------------------------------------------------------------------------
module cache_arbiter_8051 (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,
  output logic        c_rd,
  output logic        c_fill,
  output logic [15:0] c_addr,
  output logic [7:0]  c_wdata,
  input  logic        c_hit,
  input  logic [7:0]  c_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [7:0]  m_wdata,
  input  logic        m_ack,
  input  logic [7:0]  m_rdata,
  output logic        busy,
  output logic        gnt,
  output logic [15:0] miss_cnt
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOOKUP  = 3'd1;
  localparam logic [2:0] COMPARE = 3'd2;
  localparam logic [2:0] MEM     = 3'd3;
  localparam logic [2:0] FILL    = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  logic [2:0]  state_reg;
  logic [15:0] addr_reg;
  logic        wr_reg;
  logic [7:0]  wdata_reg;

  // Port chosen if a grant is made this cycle (0 or 1).
  logic        pick;
  logic [15:0] sel_addr;
  logic        sel_wr;
  logic [7:0]  sel_wdata;

`ifdef CACHE_ARB_FIXED_PRIO_EN
  // req0 wins whenever it is present.
  assign pick = ~req0;
`else
  // Port granted most recently; resets to 1 so port 0 wins the first tie.
  logic last_grant;
  // A lone request wins; on a tie the port not granted last wins.
  assign pick = req1 & (~req0 | ~last_grant);
`endif

  assign sel_addr  = pick ? addr1  : addr0;
  assign sel_wr    = pick ? wr1    : wr0;
  assign sel_wdata = pick ? wdata1 : wdata0;

  // Registered outputs are loaded on the transition into the state that
  // owns them, so they are visible for the whole cycle spent in that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wr_reg    <= 1'b0;
      wdata_reg <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      c_rd      <= 1'b0;
      c_fill    <= 1'b0;
      c_addr    <= '0;
      c_wdata   <= '0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      busy      <= 1'b0;
      gnt       <= 1'b0;
      miss_cnt  <= '0;
`ifndef CACHE_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      // Strobes are single-cycle unless re-armed below.
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      c_rd   <= 1'b0;
      c_fill <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (req0 | req1) begin
            gnt       <= pick;
            busy      <= 1'b1;
            addr_reg  <= sel_addr;
            wr_reg    <= sel_wr;
            wdata_reg <= sel_wdata;
`ifndef CACHE_ARB_FIXED_PRIO_EN
            last_grant <= pick;
`endif
            if (sel_wr) begin
              // Writes skip the lookup and go straight to external memory.
              state_reg <= MEM;
              m_req     <= 1'b1;
              m_we      <= 1'b1;
              m_addr    <= sel_addr;
              m_wdata   <= sel_wdata;
            end else begin
              state_reg <= LOOKUP;
              c_rd      <= 1'b1;
              c_addr    <= sel_addr;
            end
          end
        end

        LOOKUP: begin
          // c_rd was raised on entry; the cache answers in COMPARE.
          state_reg <= COMPARE;
        end

        COMPARE: begin
          if (c_hit) begin
            rdata     <= c_rdata;
            ack0      <= ~gnt;
            ack1      <= gnt;
            state_reg <= RESP;
          end else begin
            if (miss_cnt != 16'hFFFF) begin
              miss_cnt <= miss_cnt + 16'd1;
            end
            state_reg <= MEM;
            m_req     <= 1'b1;
            m_we      <= 1'b0;
            m_addr    <= addr_reg;
            m_wdata   <= wdata_reg;
          end
        end

        MEM: begin
          if (m_ack) begin
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            c_fill    <= 1'b1;
            c_addr    <= addr_reg;
            // c_wdata doubles as the holding register for refill data.
            c_wdata   <= wr_reg ? wdata_reg : m_rdata;
            state_reg <= FILL;
          end
        end

        FILL: begin
          if (!wr_reg) begin
            rdata <= c_wdata;
          end
          ack0      <= ~gnt;
          ack1      <= gnt;
          state_reg <= RESP;
        end

        RESP: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
